// File: rtl/toysram_16x12_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : toysram_16x12_ctl_if
//  Description : Bundle of every non-clock signal of toysram_16x12_ctl.
//                Carries the request/response side (ready, rd*/wr* requests,
//                rd*_dat / rd*_dat_val) and the array side (RWL0/RWL1/WWL
//                wordlines, WBL/WBLb write bitlines, RBL0/RBL1 read bitlines).
//                Bit 0 is the MSB of every bus.
//  Modports    : slave  - the controller
//                master - its environment (requester plus the subarray)
//  Revision    : 1.0 - initial release
// ============================================================================
interface toysram_16x12_ctl_if;
    // request / response side
    logic        ready;
    logic        rd0_val;
    logic [0:3]  rd0_adr;
    logic        rd1_val;
    logic [0:3]  rd1_adr;
    logic        wr_val;
    logic [0:3]  wr_adr;
    logic [0:11] wr_dat;
    logic        rd0_dat_val;
    logic [0:11] rd0_dat;
    logic        rd1_dat_val;
    logic [0:11] rd1_dat;
    // array side
    logic [0:15] RWL0;
    logic [0:15] RWL1;
    logic [0:15] WWL;
    logic [0:11] WBL;
    logic [0:11] WBLb;
    logic [0:11] RBL0;
    logic [0:11] RBL1;

    modport slave (
        output ready,
        input  rd0_val, rd0_adr, rd1_val, rd1_adr,
        input  wr_val, wr_adr, wr_dat,
        output rd0_dat_val, rd0_dat, rd1_dat_val, rd1_dat,
        output RWL0, RWL1, WWL, WBL, WBLb,
        input  RBL0, RBL1
    );

    // The environment both issues requests and models the subarray, so it
    // also drives the read bitlines.
    modport master (
        input  ready,
        output rd0_val, rd0_adr, rd1_val, rd1_adr,
        output wr_val, wr_adr, wr_dat,
        input  rd0_dat_val, rd0_dat, rd1_dat_val, rd1_dat,
        input  RWL0, RWL1, WWL, WBL, WBLb,
        output RBL0, RBL1
    );
endinterface
`default_nettype wire

// File: rtl/toysram_16x12_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : toysram_16x12_ctl
//  Description : Port controller for the toysram_16x12 subarray. Converts
//                read/write requests into one-cycle one-hot wordline pulses
//                and complementary write bitlines, captures read bitlines
//                into registered read data one edge later, and clears all 16
//                rows after every reset before raising ready.
//  Ports       : clk   - sole clock, rising edge
//                reset - synchronous, active-high
//                bus   - toysram_16x12_ctl_if.slave (requests, read data,
//                        wordlines and bitlines)
//  Parameters  : RBL_INV - 1: read bitlines are active-low, 0: active-high
//  Revision    : 1.0 - initial release
// ============================================================================
module toysram_16x12_ctl #(
    parameter int RBL_INV = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    toysram_16x12_ctl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [3:0] c_last_row = 4'd15;

    state_t     r_state;
    logic [3:0] r_icnt;      // row currently being cleared during init
    logic       r_rd0_pend;  // port 0 read accepted at the previous edge
    logic       r_rd1_pend;
    logic       r_rd0_byp;   // that read collided with the same-edge write
    logic       r_rd1_byp;

    function automatic logic [0:15] onehot(input logic [3:0] row);
        logic [0:15] v;
        v      = '0;
        v[row] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:11] capture(input logic [0:11] rbl);
        return (RBL_INV != 0) ? ~rbl : rbl;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_RESET;
            r_icnt          <= 4'd0;
            r_rd0_pend      <= 1'b0;
            r_rd1_pend      <= 1'b0;
            r_rd0_byp       <= 1'b0;
            r_rd1_byp       <= 1'b0;
            bus.ready       <= 1'b0;
            bus.RWL0        <= '0;
            bus.RWL1        <= '0;
            bus.WWL         <= '0;
            bus.WBL         <= '0;
            bus.WBLb        <= '0;
            bus.rd0_dat     <= '0;
            bus.rd1_dat     <= '0;
            bus.rd0_dat_val <= 1'b0;
            bus.rd1_dat_val <= 1'b0;
        end else begin
            // Wordlines and bitlines are pulses: cleared every edge unless
            // re-asserted below.
            bus.RWL0        <= '0;
            bus.RWL1        <= '0;
            bus.WWL         <= '0;
            bus.WBL         <= '0;
            bus.WBLb        <= '0;
            bus.rd0_dat_val <= 1'b0;
            bus.rd1_dat_val <= 1'b0;
            r_rd0_pend      <= 1'b0;
            r_rd1_pend      <= 1'b0;
            r_rd0_byp       <= 1'b0;
            r_rd1_byp       <= 1'b0;

            // Capture stage. On a collision the array output is undefined, so
            // the write data (still held on WBL this cycle) is returned instead.
            if (r_rd0_pend) begin
                bus.rd0_dat_val <= 1'b1;
                bus.rd0_dat     <= r_rd0_byp ? bus.WBL : capture(bus.RBL0);
            end
            if (r_rd1_pend) begin
                bus.rd1_dat_val <= 1'b1;
                bus.rd1_dat     <= r_rd1_byp ? bus.WBL : capture(bus.RBL1);
            end

            case (r_state)
                ST_RESET: begin
                    r_state  <= ST_INIT;
                    r_icnt   <= 4'd0;
                    bus.WWL  <= onehot(4'd0);
                    bus.WBLb <= '1;
                end
                ST_INIT: begin
                    if (r_icnt == c_last_row) begin
                        r_state   <= ST_RUN;
                        bus.ready <= 1'b1;
                    end else begin
                        r_icnt   <= 4'(r_icnt + 4'd1);
                        bus.WWL  <= onehot(4'(r_icnt + 4'd1));
                        bus.WBLb <= '1;
                    end
                end
                ST_RUN: begin
                    // ready is constantly high here, so every valid request
                    // is accepted.
                    if (bus.rd0_val) begin
                        bus.RWL0   <= onehot(bus.rd0_adr);
                        r_rd0_pend <= 1'b1;
                        r_rd0_byp  <= bus.wr_val && (bus.wr_adr == bus.rd0_adr);
                    end
                    if (bus.rd1_val) begin
                        bus.RWL1   <= onehot(bus.rd1_adr);
                        r_rd1_pend <= 1'b1;
                        r_rd1_byp  <= bus.wr_val && (bus.wr_adr == bus.rd1_adr);
                    end
                    if (bus.wr_val) begin
                        bus.WWL  <= onehot(bus.wr_adr);
                        bus.WBL  <= bus.wr_dat;
                        bus.WBLb <= ~bus.wr_dat;
                    end
                end
                default: begin
                    r_state   <= ST_RESET;
                    bus.ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_toysram_16x12_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toysram_16x12_ctl
//  Description : Self-checking bench for toysram_16x12_ctl. Two controllers
//                (active-low and active-high read bitlines) receive the same
//                requests; each drives its own behavioural subarray. A model
//                of the architectural row contents and the edge count since
//                reset release predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_toysram_16x12_ctl;

    localparam logic [0:11] c_junk = 12'hBAD;  // array output on a collision

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    toysram_16x12_ctl_if ba ();
    toysram_16x12_ctl_if bb ();

    toysram_16x12_ctl #(.RBL_INV(1)) dut_a (.clk(clk), .reset(reset), .bus(ba));
    toysram_16x12_ctl #(.RBL_INV(0)) dut_b (.clk(clk), .reset(reset), .bus(bb));

    // ---------------- request stimulus (shared by both controllers) -------
    logic        rd0_val, rd1_val, wr_val;
    logic [0:3]  rd0_adr, rd1_adr, wr_adr;
    logic [0:11] wr_dat;

    assign ba.rd0_val = rd0_val;  assign bb.rd0_val = rd0_val;
    assign ba.rd0_adr = rd0_adr;  assign bb.rd0_adr = rd0_adr;
    assign ba.rd1_val = rd1_val;  assign bb.rd1_val = rd1_val;
    assign ba.rd1_adr = rd1_adr;  assign bb.rd1_adr = rd1_adr;
    assign ba.wr_val  = wr_val;   assign bb.wr_val  = wr_val;
    assign ba.wr_adr  = wr_adr;   assign bb.wr_adr  = wr_adr;
    assign ba.wr_dat  = wr_dat;   assign bb.wr_dat  = wr_dat;

    // ---------------- behavioural subarrays (non-zero power-up garbage) ----
    logic [0:11] mem_a [16] = '{12'h3A1, 12'h7F2, 12'h123, 12'h9C4, 12'hE05, 12'h0B6,
                                12'h5D7, 12'hA08, 12'h6E9, 12'h1FA, 12'hC0B, 12'h2AC,
                                12'hD3D, 12'h84E, 12'h4BF, 12'hFFF};
    logic [0:11] mem_b [16] = '{12'h3A1, 12'h7F2, 12'h123, 12'h9C4, 12'hE05, 12'h0B6,
                                12'h5D7, 12'hA08, 12'h6E9, 12'h1FA, 12'hC0B, 12'h2AC,
                                12'hD3D, 12'h84E, 12'h4BF, 12'hFFF};

    always @(posedge clk) begin
        for (int r = 0; r < 16; r++) begin
            if (ba.WWL[r]) mem_a[r] <= ba.WBL;
            if (bb.WWL[r]) mem_b[r] <= bb.WBL;
        end
    end

    // Array A has active-low bitlines, array B active-high.
    always_comb begin
        logic [0:11] d0a, d1a, d0b, d1b;
        d0a = '0; d1a = '0; d0b = '0; d1b = '0;
        for (int r = 0; r < 16; r++) begin
            if (ba.RWL0[r]) d0a = ba.WWL[r] ? c_junk : mem_a[r];
            if (ba.RWL1[r]) d1a = ba.WWL[r] ? c_junk : mem_a[r];
            if (bb.RWL0[r]) d0b = bb.WWL[r] ? c_junk : mem_b[r];
            if (bb.RWL1[r]) d1b = bb.WWL[r] ? c_junk : mem_b[r];
        end
        ba.RBL0 = ~d0a;
        ba.RBL1 = ~d1a;
        bb.RBL0 = d0b;
        bb.RBL1 = d1b;
    end

    // ---------------- checking helpers -------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [0:15] oh(input int a);
        logic [0:15] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // ---------------- reference model --------------------------------------
    // m_rel = number of edges with reset low since the last reset edge;
    // edge E0 sees m_rel == 0. gold[] holds what each row architecturally
    // contains.
    int          m_rel = 0;
    logic [0:11] gold [16];
    logic        m_p0 = 1'b0, m_p1 = 1'b0;
    logic [0:11] m_d0, m_d1;

    logic        exp_ready, exp_v0, exp_v1;
    logic [0:15] exp_rwl0, exp_rwl1, exp_wwl;
    logic [0:11] exp_wbl, exp_wblb, exp_d0, exp_d1;

    always @(posedge clk) begin
        exp_rwl0 <= '0; exp_rwl1 <= '0; exp_wwl <= '0;
        exp_wbl  <= '0; exp_wblb <= '0;
        m_p0     <= 1'b0; m_p1 <= 1'b0;
        if (reset) begin
            m_rel     <= 0;
            exp_ready <= 1'b0;
            exp_v0    <= 1'b0; exp_v1 <= 1'b0;
            exp_d0    <= '0;   exp_d1 <= '0;
        end else begin
            if (m_rel < 1000) m_rel <= m_rel + 1;
            exp_v0 <= m_p0;
            exp_v1 <= m_p1;
            if (m_p0) exp_d0 <= m_d0;
            if (m_p1) exp_d1 <= m_d1;
            if (m_rel <= 15) begin
                exp_ready      <= 1'b0;
                exp_wwl        <= oh(m_rel);
                exp_wblb       <= 12'hFFF;
                gold[m_rel]    <= '0;
            end else if (m_rel == 16) begin
                exp_ready <= 1'b1;
            end else begin
                if (rd0_val) begin
                    exp_rwl0 <= oh(int'(rd0_adr));
                    m_p0     <= 1'b1;
                    m_d0     <= (wr_val && wr_adr == rd0_adr) ? wr_dat : gold[rd0_adr];
                end
                if (rd1_val) begin
                    exp_rwl1 <= oh(int'(rd1_adr));
                    m_p1     <= 1'b1;
                    m_d1     <= (wr_val && wr_adr == rd1_adr) ? wr_dat : gold[rd1_adr];
                end
                if (wr_val) begin
                    exp_wwl        <= oh(int'(wr_adr));
                    exp_wbl        <= wr_dat;
                    exp_wblb       <= ~wr_dat;
                    gold[wr_adr]   <= wr_dat;
                end
            end
        end
    end

    // ---------------- per-cycle compare ------------------------------------
    logic started = 1'b0;
    always @(posedge clk) started <= 1'b1;

    task automatic cmp(input string d, input logic rdy, input logic [0:15] r0,
                       input logic [0:15] r1, input logic [0:15] w,
                       input logic [0:11] wbl, input logic [0:11] wblb,
                       input logic v0, input logic [0:11] d0,
                       input logic v1, input logic [0:11] d1);
        chk({d, ".ready"},       32'(rdy),  32'(exp_ready));
        chk({d, ".RWL0"},        32'(r0),   32'(exp_rwl0));
        chk({d, ".RWL1"},        32'(r1),   32'(exp_rwl1));
        chk({d, ".WWL"},         32'(w),    32'(exp_wwl));
        chk({d, ".WBL"},         32'(wbl),  32'(exp_wbl));
        chk({d, ".WBLb"},        32'(wblb), 32'(exp_wblb));
        chk({d, ".rd0_dat_val"}, 32'(v0),   32'(exp_v0));
        chk({d, ".rd0_dat"},     32'(d0),   32'(exp_d0));
        chk({d, ".rd1_dat_val"}, 32'(v1),   32'(exp_v1));
        chk({d, ".rd1_dat"},     32'(d1),   32'(exp_d1));
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp("A", ba.ready, ba.RWL0, ba.RWL1, ba.WWL, ba.WBL, ba.WBLb,
                ba.rd0_dat_val, ba.rd0_dat, ba.rd1_dat_val, ba.rd1_dat);
            cmp("B", bb.ready, bb.RWL0, bb.RWL1, bb.WWL, bb.WBL, bb.WBLb,
                bb.rd0_dat_val, bb.rd0_dat, bb.rd1_dat_val, bb.rd1_dat);
        end
    end

    // ---------------- directed stimulus with literal expectations ----------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd0_val = 1'b0; rd1_val = 1'b0; wr_val = 1'b0;
    endtask

    initial begin
        int run_len;
        reset = 1'b1;
        idle();
        rd0_adr = '0; rd1_adr = '0; wr_adr = '0; wr_dat = '0;
        tick(3);
        chk("reset_ready", 32'(ba.ready), 32'h0);
        chk("reset_wwl",   32'(ba.WWL),   32'h0);

        // Release reset with requests pending: they must be ignored.
        reset = 1'b0;
        rd0_val = 1'b1; rd0_adr = 4'd2;
        wr_val  = 1'b1; wr_adr  = 4'd7; wr_dat = 12'hFFF;
        tick(1);
        chk("init_first_wwl",  32'(ba.WWL),  32'h8000);
        chk("init_first_wblb", 32'(ba.WBLb), 32'hFFF);
        tick(15);
        chk("init_last_wwl",   32'(ba.WWL),  32'h0001);
        tick(1);
        chk("init_done_ready", 32'(ba.ready), 32'h1);
        chk("init_done_wwl",   32'(ba.WWL),   32'h0);
        idle();

        // All rows must read back as cleared.
        for (int i = 0; i < 16; i++) begin
            rd0_val = 1'b1; rd0_adr = 4'(i);
            rd1_val = 1'b1; rd1_adr = 4'(15 - i);
            tick(1);
        end
        idle();
        tick(3);

        // Write row 5, read it on port 0 two cycles later.
        wr_val = 1'b1; wr_adr = 4'd5; wr_dat = 12'hA5C;
        tick(1);
        chk("wr5_wwl",  32'(ba.WWL),  32'h0400);
        chk("wr5_wbl",  32'(ba.WBL),  32'hA5C);
        chk("wr5_wblb", 32'(ba.WBLb), 32'h5A3);
        idle();
        tick(1);
        chk("wr5_wwl_closed", 32'(ba.WWL), 32'h0);
        rd0_val = 1'b1; rd0_adr = 4'd5;
        tick(1);
        idle();
        tick(1);
        chk("rd5_val_a", 32'(ba.rd0_dat_val), 32'h1);
        chk("rd5_dat_a", 32'(ba.rd0_dat),     32'hA5C);
        chk("rd5_dat_b", 32'(bb.rd0_dat),     32'hA5C);
        tick(1);

        // Same-edge write and dual read of row 3: bypass.
        wr_val = 1'b1; wr_adr = 4'd3; wr_dat = 12'h123;
        rd0_val = 1'b1; rd0_adr = 4'd3;
        rd1_val = 1'b1; rd1_adr = 4'd3;
        tick(1);
        idle();
        tick(1);
        chk("byp_rd0_a", 32'(ba.rd0_dat), 32'h123);
        chk("byp_rd1_a", 32'(ba.rd1_dat), 32'h123);
        chk("byp_rd0_b", 32'(bb.rd0_dat), 32'h123);
        chk("byp_rd1_b", 32'(bb.rd1_dat), 32'h123);
        tick(1);

        // Stream of 16 writes then 16 back-to-back dual reads.
        for (int i = 0; i < 16; i++) begin
            wr_val = 1'b1; wr_adr = 4'(i); wr_dat = 12'(i * 12'h111);
            tick(1);
        end
        idle();
        run_len = 0;
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) begin
                rd0_val = 1'b1; rd0_adr = 4'(k);
                rd1_val = 1'b1; rd1_adr = 4'(15 - k);
            end else begin
                idle();
            end
            tick(1);
            if (k >= 1 && ba.rd0_dat_val && ba.rd1_dat_val) run_len++;
        end
        chk("stream_val_run", 32'(run_len), 32'd16);
        tick(1);
        chk("stream_val_end", 32'(ba.rd0_dat_val), 32'h0);

        // Reset one cycle after a read request.
        rd0_val = 1'b1; rd0_adr = 4'd4;
        tick(1);
        idle();
        reset = 1'b1;
        tick(1);
        chk("rst_mid_val",  32'(ba.rd0_dat_val), 32'h0);
        chk("rst_mid_rwl0", 32'(ba.RWL0),        32'h0);
        chk("rst_mid_wwl",  32'(ba.WWL),         32'h0);
        reset = 1'b0;
        tick(1);
        chk("reinit_wwl", 32'(ba.WWL), 32'h8000);
        tick(16);
        chk("reinit_ready", 32'(ba.ready), 32'h1);

        // Row 15 held 0xFFF before reset; init must have cleared it.
        rd1_val = 1'b1; rd1_adr = 4'd15;
        tick(1);
        idle();
        tick(1);
        chk("reinit_rd15_val", 32'(bb.rd1_dat_val), 32'h1);
        chk("reinit_rd15_a",   32'(ba.rd1_dat),     32'h0);
        chk("reinit_rd15_b",   32'(bb.rd1_dat),     32'h0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
